// File: rtl/vfd_countdown.sv
// Loadable down-counter/timer with a one-cycle terminal-count pulse.
// Define VFD_COUNTDOWN_RELOAD_EN to auto-reload at terminal count (periodic tick).
module vfd_countdown #(
    parameter int c_width = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_clear,
    input  logic               i_load,
    input  logic [c_width-1:0] i_value,
    input  logic               i_enable,
    output logic [c_width-1:0] o_count,
    output logic               o_busy,
    output logic               o_done
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state, state_nxt;
    logic [c_width-1:0] count_nxt;
    logic               done_nxt;
`ifdef VFD_COUNTDOWN_RELOAD_EN
    logic [c_width-1:0] reload, reload_nxt;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            o_count <= '0;
            o_done  <= 1'b0;
`ifdef VFD_COUNTDOWN_RELOAD_EN
            reload  <= '0;
`endif
        end else begin
            state   <= state_nxt;
            o_count <= count_nxt;
            o_done  <= done_nxt;
`ifdef VFD_COUNTDOWN_RELOAD_EN
            reload  <= reload_nxt;
`endif
        end
    end

    // Priority: clear > load > decrement; at most one action per edge.
    always_comb begin
        state_nxt = state;
        count_nxt = o_count;
        done_nxt  = 1'b0;
`ifdef VFD_COUNTDOWN_RELOAD_EN
        reload_nxt = reload;
`endif
        if (i_clear) begin
            count_nxt = '0;
            state_nxt = IDLE;
        end else if (i_load) begin
            count_nxt = i_value;
            state_nxt = (i_value != '0) ? RUN : IDLE;
`ifdef VFD_COUNTDOWN_RELOAD_EN
            reload_nxt = i_value;
`endif
        end else if (state == RUN && i_enable) begin
            if (o_count > c_width'(1)) begin
                count_nxt = o_count - c_width'(1);
            end else begin
                // Terminal decrement; "<= 1" also floors a stray zero in RUN.
                done_nxt = 1'b1;
`ifdef VFD_COUNTDOWN_RELOAD_EN
                if (reload != '0) begin
                    count_nxt = reload;
                end else begin
                    count_nxt = '0;
                    state_nxt = IDLE;
                end
`else
                count_nxt = '0;
                state_nxt = IDLE;
`endif
            end
        end
    end

    assign o_busy = (state == RUN);

endmodule

// File: tb/tb_vfd_countdown.sv
// Self-checking bench for vfd_countdown: vector table, corner sequences, random vs model.
// Also covers the VFD_COUNTDOWN_RELOAD_EN build when that macro is defined.
module tb_vfd_countdown;

    localparam int W = 5;
    localparam int MAXV = (1 << W) - 1;

    logic         clk_tb = 1'b0;
    logic         rst_tb = 1'b1;
    logic         i_clear = 1'b0, i_load = 1'b0, i_enable = 1'b0;
    logic [W-1:0] i_value = '0;
    logic [W-1:0] o_count;
    logic         o_busy, o_done;

    int checks = 0;
    int failures = 0;

    vfd_countdown #(.c_width(W)) dut (
        .clk(clk_tb), .rst(rst_tb), .i_clear(i_clear), .i_load(i_load),
        .i_value(i_value), .i_enable(i_enable),
        .o_count(o_count), .o_busy(o_busy), .o_done(o_done)
    );

    always #5 clk_tb = ~clk_tb;

    // Reference: a timer holding "remaining ticks"; it runs while remaining > 0.
    int m_remaining = 0;
    int m_period = 0;
    bit m_done = 0;

    function automatic void model_reset();
        m_remaining = 0; m_period = 0; m_done = 0;
    endfunction

    function automatic void model_step(bit c, bit l, int v, bit e);
        m_done = 0;
        if (c) begin
            m_remaining = 0;
        end else if (l) begin
            m_remaining = v;
            m_period = v;
        end else if (e && m_remaining > 0) begin
            m_remaining = m_remaining - 1;
            if (m_remaining == 0) begin
                m_done = 1;
`ifdef VFD_COUNTDOWN_RELOAD_EN
                m_remaining = m_period;
`endif
            end
        end
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_out(input string name, input int cnt, input bit busy, input bit done);
        check({name, ".count"}, int'(o_count), cnt);
        check({name, ".busy"}, int'(o_busy), int'(busy));
        check({name, ".done"}, int'(o_done), int'(done));
    endtask

    task automatic check_model(input string name);
        check_out(name, m_remaining, m_remaining > 0, m_done);
    endtask

    task automatic step(input bit c, input bit l, input int v, input bit e);
        i_clear = c; i_load = l; i_value = W'(v); i_enable = e;
        @(posedge clk_tb);
        model_step(c, l, v, e);
        #1;
    endtask

    typedef struct {
        bit c; bit l; int v; bit e;
        int cnt; bit busy; bit done;
        string name;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(bit c, bit l, int v, bit e, int cnt, bit busy, bit done, string name);
        vec_t t;
        t.c = c; t.l = l; t.v = v; t.e = e;
        t.cnt = cnt; t.busy = busy; t.done = done; t.name = name;
        tbl.push_back(t);
    endfunction

    initial begin
        // Reset held, clock running: outputs at reset values.
        #23;
        check_out("reset_held", 0, 0, 0);
        #4 rst_tb = 1'b0;
        model_reset();
        @(posedge clk_tb); #1;
        check_out("reset_released", 0, 0, 0);

`ifndef VFD_COUNTDOWN_RELOAD_EN
        // Load 5, enable continuously.
        add(0,1,5,1, 5,1,0, "l5_load");
        add(0,0,0,1, 4,1,0, "l5_d1");
        add(0,0,0,1, 3,1,0, "l5_d2");
        add(0,0,0,1, 2,1,0, "l5_d3");
        add(0,0,0,1, 1,1,0, "l5_d4");
        add(0,0,0,1, 0,0,1, "l5_term");
        add(0,0,0,1, 0,0,0, "l5_floor1");
        add(0,0,0,1, 0,0,0, "l5_floor2");
        // Load 4, enable toggling.
        add(0,1,4,1, 4,1,0, "l4_load");
        add(0,0,0,0, 4,1,0, "l4_p1");
        add(0,0,0,1, 3,1,0, "l4_e1");
        add(0,0,0,0, 3,1,0, "l4_p2");
        add(0,0,0,1, 2,1,0, "l4_e2");
        add(0,0,0,0, 2,1,0, "l4_p3");
        add(0,0,0,1, 1,1,0, "l4_e3");
        add(0,0,0,0, 1,1,0, "l4_p4");
        add(0,0,0,1, 0,0,1, "l4_term");
        add(0,0,0,0, 0,0,0, "l4_after");
        // Load 3, clear on the terminal cycle, then load 0.
        add(0,1,3,1, 3,1,0, "l3_load");
        add(0,0,0,1, 2,1,0, "l3_d1");
        add(0,0,0,1, 1,1,0, "l3_d2");
        add(1,0,0,1, 0,0,0, "l3_clear");
        add(0,0,0,1, 0,0,0, "l3_idle");
        add(0,1,0,1, 0,0,0, "load0");
        add(0,0,0,1, 0,0,0, "load0_after");
        // Load 2, reload with max value on the terminal cycle.
        add(0,1,2,1, 2,1,0, "l2_load");
        add(0,0,0,1, 1,1,0, "l2_d1");
        add(1,1,7,1, 0,0,0, "clear_beats_load");
        add(0,1,2,1, 2,1,0, "l2b_load");
        add(0,0,0,1, 1,1,0, "l2b_d1");
        add(0,1,MAXV,1, MAXV,1,0, "load_on_term");

        foreach (tbl[i]) begin
            step(tbl[i].c, tbl[i].l, tbl[i].v, tbl[i].e);
            check_out(tbl[i].name, tbl[i].cnt, tbl[i].busy, tbl[i].done);
        end

        // Max count runs down: done only after MAXV enabled cycles.
        for (int k = 1; k < MAXV; k++) begin
            step(0,0,0,1);
            if (o_done !== 1'b0 || o_count !== W'(MAXV - k) || o_busy !== 1'b1)
                check_out("max_run", MAXV - k, 1, 0);
        end
        checks++;
        step(0,0,0,1);
        check_out("max_term", 0, 0, 1);
`else
        // Reload build: load 3, periodic tick every 3 enabled cycles.
        step(0,1,3,1);
        check_out("rl_load", 3, 1, 0);
        for (int k = 1; k <= 9; k++) begin
            step(0,0,0,1);
            check_out("rl_tick", (k % 3 == 0) ? 3 : 3 - (k % 3), 1, (k % 3 == 0));
        end
        step(0,0,0,0);
        check_out("rl_pause", 3, 1, 0);
        step(1,0,0,1);
        check_out("rl_clear", 0, 0, 0);
        step(0,1,0,1);
        check_out("rl_load0", 0, 0, 0);
`endif

        // Asynchronous reset mid-run at count 7.
        step(0,1,9,1);
        step(0,0,0,1);
        step(0,0,0,1);
        check_out("pre_async", 7, 1, 0);
        #2 rst_tb = 1'b1;
        #1;
        check_out("async_rst", 0, 0, 0);
        #3 rst_tb = 1'b0;
        model_reset();
        @(posedge clk_tb); #1;
        check_out("post_async", 0, 0, 0);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 400; n++) begin
            bit c, l, e;
            int v;
            c = ($urandom_range(0, 29) == 0);
            l = ($urandom_range(0, 11) == 0);
            e = ($urandom_range(0, 9) < 7);
            case ($urandom_range(0, 9))
                0:       v = 0;
                1:       v = MAXV;
                default: v = $urandom_range(1, 8);
            endcase
            step(c, l, v, e);
            check_model("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, expected end before %0t", $time);
        $fatal(1);
    end

endmodule
